// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        ERR   = 2'd3
    } fetch_state_e;

    localparam logic        PC_SEL_SEQ = 1'b0;
    localparam logic        PC_SEL_ALU = 1'b1;
    localparam logic [31:0] INSN_NOP   = 32'h0000_0013;

endpackage

// File: rtl/fetch_tmo_cnt.sv
// 8-bit imem response timeout counter; expired pulses on the cycle that would
// take the count past TIMEOUT_CYC-1.
module fetch_tmo_cnt #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(TIMEOUT_CYC - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 8'd1;
        end
    end

    // clear wins so a late response or redirect never trips the error
    assign expired = inc & !clr & (cnt == LAST);

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: steers PC advance/redirect, tracks one imem access and holds
// the fetched word for decode. Optional perf counters under FETCH_PERF_EN.
//
// state | meaning
// BOOT  | first cycle after reset, PC holds reset vector
// FETCH | issuing/awaiting imem while the output slot is free
// DRAIN | one stale response outstanding after a redirect, discard it
// ERR   | imem timeout, absorbing until reset
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_insn,
    input  logic        i_insn_ready,
    output logic        o_imem_req,
    output logic        o_pc_en,
    output logic        o_pc_sel,
    output logic [31:0] o_alu_data,
    output logic [31:0] o_insn,
    output logic        o_insn_valid,
    output logic        o_err,
    output logic [31:0] o_perf_fetch,
    output logic [31:0] o_perf_stall
);

    fetch_state_e state, state_next;
    logic [31:0]  insn_q;
    logic         valid_q;
    logic         slot_free;
    logic         redir;
    logic         take;
    logic         tmo_inc;
    logic         tmo_clr;
    logic         tmo_expired;
    logic         unused_pc_lsb;

    assign unused_pc_lsb = ^i_redirect_pc[1:0];

    assign slot_free = !valid_q | i_insn_ready;
    assign redir     = i_redirect & (state != ERR);
    assign tmo_inc   = (((state == FETCH) & slot_free) | (state == DRAIN)) & !i_imem_rvalid;
    assign tmo_clr   = (state != ERR) & (i_imem_rvalid | i_redirect);

    fetch_tmo_cnt #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_tmo (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .inc    (tmo_inc),
        .clr    (tmo_clr),
        .expired(tmo_expired)
    );

    always_comb begin
        state_next = state;
        o_imem_req = 1'b0;
        o_pc_en    = 1'b0;
        o_pc_sel   = PC_SEL_SEQ;
        o_alu_data = '0;
        take       = 1'b0;
        case (state)
            BOOT: state_next = FETCH;
            FETCH: begin
                o_imem_req = slot_free;
                if (redir) begin
                    if (slot_free && !i_imem_rvalid) state_next = DRAIN;
                end else if (slot_free && i_imem_rvalid) begin
                    take    = 1'b1;
                    o_pc_en = 1'b1;
                end
            end
            DRAIN: begin
                o_imem_req = 1'b1;
                if (!redir && i_imem_rvalid) state_next = FETCH;
            end
            ERR: ;
        endcase
        if (redir) begin
            o_pc_en    = 1'b1;
            o_pc_sel   = PC_SEL_ALU;
            o_alu_data = {i_redirect_pc[31:2], 2'b00};
        end
        if (tmo_expired) state_next = ERR;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= BOOT;
            insn_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state <= state_next;
            if (redir) begin
                valid_q <= 1'b0;
            end else if (take) begin
                valid_q <= 1'b1;
                insn_q  <= i_insn;
            end else if (valid_q && i_insn_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign o_insn       = insn_q;
    assign o_insn_valid = valid_q;
    assign o_err        = (state == ERR);

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_stall;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            perf_fetch <= '0;
            perf_stall <= '0;
        end else if (state != ERR) begin
            if (valid_q && i_insn_ready)  perf_fetch <= perf_fetch + 32'd1;
            if (valid_q && !i_insn_ready) perf_stall <= perf_stall + 32'd1;
        end
    end

    assign o_perf_fetch = perf_fetch;
    assign o_perf_stall = perf_stall;
`else
    assign o_perf_fetch = '0;
    assign o_perf_stall = '0;
`endif

endmodule
